// File: rtl/axis_frame_arbiter.sv
// Two-input AXI4-Stream arbiter with frame-granular round-robin grants,
// per-port completed-frame counters and a sticky bad start-of-frame flag.
module axis_frame_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_CNT_WIDTH        = 16
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  input  logic                            S0_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S0_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S0_AXIS_TSTRB,
  input  logic                            S0_AXIS_TLAST,
  input  logic                            S0_AXIS_TUSER,
  output logic                            S0_AXIS_TREADY,
  input  logic                            S1_AXIS_TVALID,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S1_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S1_AXIS_TSTRB,
  input  logic                            S1_AXIS_TLAST,
  input  logic                            S1_AXIS_TUSER,
  output logic                            S1_AXIS_TREADY,
  output logic                            M_AXIS_TVALID,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TUSER,
  input  logic                            M_AXIS_TREADY,
  output logic [1:0]                      GRANT,
  output logic [C_CNT_WIDTH-1:0]          FRAME_CNT0,
  output logic [C_CNT_WIDTH-1:0]          FRAME_CNT1,
  output logic                            SOF_ERR
);

  typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic                   r_lastServed;
  logic                   r_firstBeat;
  logic                   r_sofErr;
  logic [C_CNT_WIDTH-1:0] r_frameCnt0;
  logic [C_CNT_WIDTH-1:0] r_frameCnt1;

  logic w_hs0;
  logic w_hs1;
  logic w_hs;
  logic w_hsUser;
  logic w_end0;
  logic w_end1;
  logic w_start;

  assign w_hs0    = (r_state == BUSY0) && S0_AXIS_TVALID && M_AXIS_TREADY;
  assign w_hs1    = (r_state == BUSY1) && S1_AXIS_TVALID && M_AXIS_TREADY;
  assign w_hs     = w_hs0 || w_hs1;
  assign w_hsUser = (r_state == BUSY0) ? S0_AXIS_TUSER : S1_AXIS_TUSER;
  assign w_end0   = w_hs0 && S0_AXIS_TLAST;
  assign w_end1   = w_hs1 && S1_AXIS_TLAST;
  assign w_start  = (r_state == IDLE) && (S0_AXIS_TVALID || S1_AXIS_TVALID);

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_lastServed=1 means port 1 went last, so a tie goes to port 0
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (S0_AXIS_TVALID && (!S1_AXIS_TVALID || r_lastServed)) begin
          w_nextState = BUSY0;
        end else if (S1_AXIS_TVALID) begin
          w_nextState = BUSY1;
        end
      end
      BUSY0: begin
        if (w_end0) begin
          w_nextState = IDLE;
        end
      end
      BUSY1: begin
        if (w_end1) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    M_AXIS_TVALID  = 1'b0;
    M_AXIS_TDATA   = '0;
    M_AXIS_TSTRB   = '0;
    M_AXIS_TLAST   = 1'b0;
    M_AXIS_TUSER   = 1'b0;
    S0_AXIS_TREADY = 1'b0;
    S1_AXIS_TREADY = 1'b0;
    GRANT          = 2'b00;
    case (r_state)
      BUSY0: begin
        M_AXIS_TVALID  = S0_AXIS_TVALID;
        M_AXIS_TDATA   = S0_AXIS_TDATA;
        M_AXIS_TSTRB   = S0_AXIS_TSTRB;
        M_AXIS_TLAST   = S0_AXIS_TLAST;
        M_AXIS_TUSER   = S0_AXIS_TUSER;
        S0_AXIS_TREADY = M_AXIS_TREADY;
        GRANT          = 2'b01;
      end
      BUSY1: begin
        M_AXIS_TVALID  = S1_AXIS_TVALID;
        M_AXIS_TDATA   = S1_AXIS_TDATA;
        M_AXIS_TSTRB   = S1_AXIS_TSTRB;
        M_AXIS_TLAST   = S1_AXIS_TLAST;
        M_AXIS_TUSER   = S1_AXIS_TUSER;
        S1_AXIS_TREADY = M_AXIS_TREADY;
        GRANT          = 2'b10;
      end
      default: ;
    endcase
  end

  // The bad-SOF check only applies to the first accepted beat of each frame
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      r_lastServed <= 1'b1;
      r_firstBeat  <= 1'b0;
      r_sofErr     <= 1'b0;
      r_frameCnt0  <= '0;
      r_frameCnt1  <= '0;
    end else begin
      if (w_start) begin
        r_firstBeat <= 1'b1;
      end else if (w_hs) begin
        r_firstBeat <= 1'b0;
      end
      if (r_firstBeat && w_hs && !w_hsUser) begin
        r_sofErr <= 1'b1;
      end
      if (w_end0) begin
        r_lastServed <= 1'b0;
        r_frameCnt0  <= r_frameCnt0 + 1'b1;
      end
      if (w_end1) begin
        r_lastServed <= 1'b1;
        r_frameCnt1  <= r_frameCnt1 + 1'b1;
      end
    end
  end

  assign FRAME_CNT0 = r_frameCnt0;
  assign FRAME_CNT1 = r_frameCnt1;
  assign SOF_ERR    = r_sofErr;

endmodule
